keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed 7-segment display driver in the elevator controller.
- The display time-multiplexes segment outputs across digit strobes. This block time-multiplexes a 4x4 button matrix (floor calls and cabin panel) by strobing columns and reading rows.
- Debounces the reading and emits one clean, encoded key event per press to the elevator control FSM.

Parameters:
SCAN_DIV, 96, clk cycles each column is held driven; rows are sampled on the last cycle of that window (min 4)
DEBOUNCE_SCANS, 3, consecutive matching samples needed to accept a press or a release (min 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
ROW  input  4  matrix rows, active-low, externally pulled up; asynchronous to clk
COL  output  4  column strobes, active-low one-hot; exactly one bit low at all times
key_code  output  4  {row_idx[1:0], col_idx[1:0]} of the last accepted key
key_valid  output  1  one-cycle pulse when a press is accepted
key_held  output  1  high from the key_valid pulse until the release is accepted

Behaviour:
- ROW passes through a 2-FF synchronizer; all logic uses the synchronized value rs.
- Scan timer: counts 0..SCAN_DIV-1, then wraps. A "sample" is the cycle where timer == SCAN_DIV-1. The timer runs continuously in every state.
- col_idx drives COL = ~(1 << col_idx).
- Reset (async assert, sync release):
  - COL=4'b1110, col_idx=0, timer=0, state=SCAN.
  - key_code=0, key_valid=0, key_held=0, debounce count=0, synchronizer flops=4'b1111.
- Each state below lists the action taken on each sample.
- SCAN:
  - rs==4'b1111: col_idx increments mod 4 on the cycle after the sample, so each column is driven for exactly SCAN_DIV cycles.
  - any rs bit low: cand_row = lowest-index low bit; hold col_idx; cnt=1; go to DEBOUNCE.
- DEBOUNCE:
  - rs[cand_row]==0: cnt++.
  - rs[cand_row]==1: cnt=0; col_idx increments; go to SCAN (no event).
  - When cnt reaches DEBOUNCE_SCANS: key_code={cand_row,col_idx}; key_valid=1 for exactly one cycle; key_held=1; cnt=0; go to HELD.
  - With DEBOUNCE_SCANS=1, the first sample goes straight from SCAN to the accept action.
- HELD:
  - Column is frozen.
  - rs[cand_row]==1: cnt++.
  - rs[cand_row]==0: cnt=0.
  - When cnt reaches DEBOUNCE_SCANS: key_held=0; col_idx increments; go to SCAN.
  - Other keys pressed meanwhile are ignored (no rollover).
- Latency for a clean press in the currently driven column: key_valid asserts (DEBOUNCE_SCANS-1)*SCAN_DIV cycles after the first detecting sample, plus 1 registered cycle. Add 2 cycles of synchronizer delay from the ROW edge.
- Multiple rows low in one column: the lowest row index wins; the other rows are ignored until release.
- key_code holds its value until the next accepted press. key_valid never asserts twice for one press.
- Reset mid-press: all state is cleared. A key still held when reset deasserts is detected afresh and produces a new event.

Test Plan:
- SCAN_DIV=4, DEBOUNCE_SCANS=3, no keys:
  - Required: COL cycles 1110→1101→1011→0111→1110, each value for exactly 4 clk.
  - Required: key_valid and key_held never assert.
- Hold ROW[2]=0 whenever COL[1]=0, held long-term:
  - Required: exactly one key_valid pulse, with key_code=4'b1001.
  - Required: COL stays 1101 while key_held=1.
  - Release → key_held drops after 3 high samples, then scanning resumes at COL=1011.
- Bounce: ROW[0] low for 1 sample, high for 1 sample, in column 3:
  - Required: no key_valid; FSM returns to SCAN and the next column driven is 1110.
- ROW=4'b0101 (rows 1 and 3 low) in column 0:
  - Required: key_code=4'b0100, single pulse.
- During HELD, press a second key in another column:
  - Required: no new event; after release, the second key is detected normally on a later scan.
- Assert reset (0) during DEBOUNCE with the key still held:
  - Required: outputs return to their reset values immediately.
  - After reset=1, the press is re-detected and exactly one key_valid is produced.

Source files
------------

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low button matrix by strobing one column at a time and
//   reading the rows. The row reading is debounced, and each press produces one
//   encoded key event for the elevator control FSM.
//
// Parameters
//   SCAN_DIV        clk cycles each column is driven; rows are sampled on the
//                   last cycle of that window (min 4)
//   DEBOUNCE_SCANS  consecutive matching samples needed to accept a press or a
//                   release (min 1)
//
// Ports
//   clk        system clock
//   reset      asynchronous active-low reset
//   ROW[3:0]   matrix rows, active-low, pulled up, asynchronous to clk
//   COL[3:0]   column strobes, active-low one-hot
//   key_code   {row_idx, col_idx} of the last accepted key
//   key_valid  one-cycle pulse when a press is accepted
//   key_held   high from the key_valid pulse until the release is accepted
module keypad_scanner #(
  parameter int SCAN_DIV       = 96,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] C_DONE = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD
  } state_t;

  state_t          state, state_n;
  logic [3:0]      sync1, rs;
  logic [TW-1:0]   timer;
  logic            sample;
  logic [1:0]      col_idx, col_n;
  logic [1:0]      cand_row, row_n;
  logic [1:0]      low_idx;
  logic [CW-1:0]   cnt, cnt_n, cnt_inc;
  logic [3:0]      code_n;
  logic            valid_n, held_n;

  // Two-stage synchronizer for the asynchronous row inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '1;
      rs    <= '1;
    end else begin
      sync1 <= ROW;
      rs    <= sync1;
    end
  end

  // Free-running scan timer. It keeps running in every state, so samples stay
  // exactly SCAN_DIV cycles apart.
  assign sample = (timer == T_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
    end else if (sample) begin
      timer <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Lowest-index low row wins when several rows are pressed together.
  always_comb begin
    low_idx = 2'd3;
    if (!rs[0]) begin
      low_idx = 2'd0;
    end else if (!rs[1]) begin
      low_idx = 2'd1;
    end else if (!rs[2]) begin
      low_idx = 2'd2;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  always_comb begin
    state_n = state;
    col_n   = col_idx;
    row_n   = cand_row;
    cnt_n   = cnt;
    code_n  = key_code;
    valid_n = 1'b0;
    held_n  = key_held;
    if (sample) begin
      case (state)
        SCAN: begin
          if (rs == 4'b1111) begin
            col_n = col_idx + 1'b1;
          end else begin
            row_n = low_idx;
            // A single required sample means the detecting sample itself
            // already accepts the press.
            if (DEBOUNCE_SCANS == 1) begin
              code_n  = {low_idx, col_idx};
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end else begin
              cnt_n   = CW'(1);
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!rs[cand_row]) begin
            if (cnt_inc == C_DONE) begin
              code_n  = {cand_row, col_idx};
              valid_n = 1'b1;
              held_n  = 1'b1;
              cnt_n   = '0;
              state_n = HELD;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n   = '0;
            col_n   = col_idx + 1'b1;
            state_n = SCAN;
          end
        end
        HELD: begin
          // Column stays frozen; other rows and columns are ignored here.
          if (rs[cand_row]) begin
            if (cnt_inc == C_DONE) begin
              held_n  = 1'b0;
              cnt_n   = '0;
              col_n   = col_idx + 1'b1;
              state_n = SCAN;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            cnt_n = '0;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = SCAN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      cand_row  <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_n;
      col_idx   <= col_n;
      cand_row  <= row_n;
      cnt       <= cnt_n;
      key_code  <= code_n;
      key_valid <= valid_n;
      key_held  <= held_n;
    end
  end

  assign COL = ~(4'b0001 << col_idx);

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4 and DEBOUNCE_SCANS=3. A matrix model
// drives ROW from the pressed-key map and the active column. Expected key
// events go into a queue and are checked whenever key_valid pulses.
module tb_keypad_scanner;

  logic       clk;
  logic       rst_n;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0] pcol [4];   // pcol[c][r] = key at row r, column c pressed
  logic [3:0] force_low;  // rows forced low regardless of the column
  logic [3:0] sb [$];
  logic       prev_valid = 1'b0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int         col;
    logic [3:0] rows;
    logic [3:0] code;
  } vec_t;
  vec_t vt [5];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .ROW      (ROW),
    .COL      (COL),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [3:0] rv;
    rv = 4'b1111;
    for (int c = 0; c < 4; c++) begin
      if (!COL[c]) rv = rv & ~pcol[c];
    end
    ROW = rv & ~force_low;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] colpat(input int c);
    logic [3:0] v;
    v = 4'b0001 << c;
    return ~v;
  endfunction

  // Event monitor: each key_valid pulse must match the oldest expected code.
  always @(negedge clk) begin
    check("col_onehot", $countones(~COL), 1);
    if (key_valid) begin
      check("valid_width", {31'b0, prev_valid}, 0);
      if (sb.size() == 0) check("unexpected_valid", {31'b0, key_valid}, 0);
      else check("event_code", {28'b0, key_code}, {28'b0, sb.pop_front()});
    end
    prev_valid = key_valid;
  end

  task automatic wait_held(input logic lvl, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (key_held === lvl) break;
    end
    check("held_wait", {31'b0, key_held}, {31'b0, lvl});
  endtask

  // Returns on the negedge where COL has just switched to val (timer = 0).
  task automatic wait_col(input logic [3:0] val);
    logic [3:0] p;
    logic       seen;
    p = COL;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (COL == val && p != val) begin
        seen = 1'b1;
        break;
      end
      p = COL;
    end
    check("col_edge_seen", {31'b0, seen}, 1);
  endtask

  task automatic hold_and_release(input int c);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("held_col", {28'b0, COL}, {28'b0, colpat(c)});
      check("held_level", {31'b0, key_held}, 1);
    end
    pcol[c] = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("release_min", {31'b0, key_held}, 1);
    end
    wait_held(1'b0, 20);
    check("resume_col", {28'b0, COL}, {28'b0, colpat((c + 1) % 4)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1, 4'b0100, 4'b1001};
    vt[1] = '{0, 4'b1010, 4'b0100};
    vt[2] = '{3, 4'b0001, 4'b0011};
    vt[3] = '{2, 4'b1000, 4'b1110};
    vt[4] = '{0, 4'b0001, 4'b0000};
    for (int c = 0; c < 4; c++) pcol[c] = 4'b0000;
    force_low = 4'b0000;
    rst_n = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_col", {28'b0, COL}, 32'hE);
    check("rst_code", {28'b0, key_code}, 0);
    check("rst_valid", {31'b0, key_valid}, 0);
    check("rst_held", {31'b0, key_held}, 0);

    // Idle scan: each column driven for exactly 4 cycles
    rst_n = 1'b1;
    for (int k = 1; k < 24; k++) begin
      @(negedge clk);
      check("idle_col", {28'b0, COL}, {28'b0, colpat((k / 4) % 4)});
      check("idle_valid", {31'b0, key_valid}, 0);
      check("idle_held", {31'b0, key_held}, 0);
    end

    // Press latency from the start of the column window
    wait_col(4'b1101);
    pcol[1] = 4'b0100;
    sb.push_back(4'b1001);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      check("latency_valid", {31'b0, key_valid}, (i == 12) ? 1 : 0);
    end
    check("latency_held", {31'b0, key_held}, 1);
    check("latency_code", {28'b0, key_code}, 32'h9);
    hold_and_release(1);

    // Table-driven single presses
    for (int e = 0; e < 5; e++) begin
      pcol[vt[e].col] = vt[e].rows;
      sb.push_back(vt[e].code);
      wait_held(1'b1, 100);
      check("vec_code", {28'b0, key_code}, {28'b0, vt[e].code});
      hold_and_release(vt[e].col);
      repeat (3) @(negedge clk);
    end

    // Bounce: row 0 low for one sample in column 3, then released
    wait_col(4'b0111);
    force_low = 4'b0001;
    repeat (4) @(negedge clk);
    check("bounce_detect_col", {28'b0, COL}, 32'h7);
    force_low = 4'b0000;
    repeat (3) @(negedge clk);
    check("bounce_hold_col", {28'b0, COL}, 32'h7);
    @(negedge clk);
    check("bounce_next_col", {28'b0, COL}, 32'hE);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("bounce_no_held", {31'b0, key_held}, 0);
    end

    // Second key pressed while the first is held is ignored until release
    pcol[1] = 4'b0100;
    sb.push_back(4'b1001);
    wait_held(1'b1, 100);
    check("first_code", {28'b0, key_code}, 32'h9);
    pcol[3] = 4'b0010;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("frozen_col", {28'b0, COL}, 32'hD);
    end
    sb.push_back(4'b0111);
    pcol[1] = 4'b0000;
    wait_held(1'b0, 30);
    wait_held(1'b1, 100);
    check("second_code", {28'b0, key_code}, 32'h7);
    hold_and_release(3);

    // Reset during DEBOUNCE with the key still pressed
    wait_col(4'b1110);
    pcol[0] = 4'b1000;
    repeat (5) @(negedge clk);
    check("debounce_col", {28'b0, COL}, 32'hE);
    rst_n = 1'b0;
    #1;
    check("midrst_col", {28'b0, COL}, 32'hE);
    check("midrst_code", {28'b0, key_code}, 0);
    check("midrst_valid", {31'b0, key_valid}, 0);
    check("midrst_held", {31'b0, key_held}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(4'b1100);
    wait_held(1'b1, 100);
    check("redetect_code", {28'b0, key_code}, 32'hC);
    hold_and_release(0);

    repeat (10) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
